// File: rtl/fc_sequencer.sv
// fc_sequencer: control FSM for a tiled fully-connected layer.
// Loads the ifm vector once, then runs one compute/latch/drain pass per tile of PEs.
module fc_sequencer #(
    parameter int IFM_SIZE    = 9162,
    parameter int KERNEL_SIZE = 4096,
    parameter int TILING_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           valid_ifm,
    input  logic                           wgt_valid,
    output logic                           ifm_read,
    output logic                           wgt_read,
    output logic                           wr_buff_ifm,
    output logic                           rd_buff_ifm,
    output logic                           wr_ifm_clr,
    output logic                           rd_ifm_clr,
    output logic                           set_reg,
    output logic                           first_acc,
    output logic                           set_output,
    output logic                           valid_data,
    output logic [$clog2(TILING_SIZE)-1:0] sel_data,
    output logic [15:0]                    counter_ifm,
    output logic [15:0]                    counter_tiling,
    output logic [2:0]                     state,
    output logic                           busy,
    output logic                           done
);
    localparam int SW = $clog2(TILING_SIZE);
    localparam logic [15:0] IFM_LAST  = 16'(IFM_SIZE - 1);
    localparam logic [15:0] TILE_LAST = 16'(KERNEL_SIZE / TILING_SIZE - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(TILING_SIZE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, LATCH, DRAIN, DONE} state_t;

    state_t        state_d, state_q;
    logic [15:0]   cnt_ifm_d, cnt_ifm_q, cnt_tile_d, cnt_tile_q;
    logic [SW-1:0] sel_d, sel_q;
    logic          clr_d, clr_q;

    always_comb begin
        state_d    = state_q;
        cnt_ifm_d  = cnt_ifm_q;
        cnt_tile_d = cnt_tile_q;
        sel_d      = sel_q;
        clr_d      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = start ? LOAD : IDLE;
                clr_d   = start;
            end
            LOAD: if (valid_ifm) begin
                cnt_ifm_d = (cnt_ifm_q == IFM_LAST) ? 16'd0 : cnt_ifm_q + 16'd1;
                state_d   = (cnt_ifm_q == IFM_LAST) ? COMPUTE : LOAD;
            end
            COMPUTE: if (wgt_valid) begin
                cnt_ifm_d = (cnt_ifm_q == IFM_LAST) ? 16'd0 : cnt_ifm_q + 16'd1;
                state_d   = (cnt_ifm_q == IFM_LAST) ? LATCH : COMPUTE;
            end
            LATCH: state_d = DRAIN;
            DRAIN: if (sel_q == SEL_LAST) begin
                sel_d      = '0;
                state_d    = (cnt_tile_q == TILE_LAST) ? DONE : COMPUTE;
                cnt_tile_d = (cnt_tile_q == TILE_LAST) ? 16'd0 : cnt_tile_q + 16'd1;
            end else begin
                sel_d = sel_q + SW'(1);
            end
            DONE: begin
                state_d    = IDLE;
                cnt_ifm_d  = 16'd0;
                cnt_tile_d = 16'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_ifm_q  <= 16'd0;
            cnt_tile_q <= 16'd0;
            sel_q      <= '0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_ifm_q  <= cnt_ifm_d;
            cnt_tile_q <= cnt_tile_d;
            sel_q      <= sel_d;
            clr_q      <= clr_d;
        end
    end

    // Strobes decode the registered state, so reset zeroes them all immediately.
    assign ifm_read       = (state_q == LOAD);
    assign wr_buff_ifm    = (state_q == LOAD) && valid_ifm;
    assign wgt_read       = (state_q == COMPUTE);
    assign rd_buff_ifm    = (state_q == COMPUTE) && wgt_valid;
    assign set_reg        = rd_buff_ifm;
    assign first_acc      = (state_q == COMPUTE) && (cnt_ifm_q == 16'd0);
    assign set_output     = (state_q == LATCH);
    assign valid_data     = (state_q == DRAIN);
    assign sel_data       = sel_q;
    assign wr_ifm_clr     = clr_q;
    assign rd_ifm_clr     = clr_q || ((state_q == DRAIN) && (sel_q == SEL_LAST) && (cnt_tile_q != TILE_LAST));
    assign counter_ifm    = cnt_ifm_q;
    assign counter_tiling = cnt_tile_q;
    assign state          = state_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: directed stimulus, per-cycle comparison against a behavioural
// phase/count model, plus literal per-layer pulse counts.
module tb_fc_sequencer;
    localparam int I = 4, K = 16, T = 8, NT = K / T;

    logic clk = 0, rst_n = 0, start = 0, valid_ifm = 0, wgt_valid = 0;
    logic ifm_read, wgt_read, wr_buff_ifm, rd_buff_ifm, wr_ifm_clr, rd_ifm_clr;
    logic set_reg, first_acc, set_output, valid_data, busy, done;
    logic [2:0] sel_data;
    logic [15:0] counter_ifm, counter_tiling;
    logic [2:0] state;

    fc_sequencer #(.IFM_SIZE(I), .KERNEL_SIZE(K), .TILING_SIZE(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid_ifm(valid_ifm), .wgt_valid(wgt_valid),
        .ifm_read(ifm_read), .wgt_read(wgt_read), .wr_buff_ifm(wr_buff_ifm),
        .rd_buff_ifm(rd_buff_ifm), .wr_ifm_clr(wr_ifm_clr), .rd_ifm_clr(rd_ifm_clr),
        .set_reg(set_reg), .first_acc(first_acc), .set_output(set_output),
        .valid_data(valid_data), .sel_data(sel_data), .counter_ifm(counter_ifm),
        .counter_tiling(counter_tiling), .state(state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(string n, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask

    // Model: phase numbers follow the published state codes; words/weights/beats are plain counts.
    int ph = 0, words = 0, beat = 0, tile = 0, clr = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; words = 0; beat = 0; tile = 0; clr = 0;
        end else begin
            clr = int'(ph == 0 && start);
            if (ph == 0) ph = start ? 1 : 0;
            else if (ph == 1 || ph == 2) begin
                if ((ph == 1 && valid_ifm) || (ph == 2 && wgt_valid)) begin
                    words++;
                    if (words == I) begin words = 0; ph++; end
                end
            end else if (ph == 3) begin ph = 4; beat = 0; end
            else if (ph == 4) begin
                beat++;
                if (beat == T) begin
                    beat = 0;
                    if (tile < NT - 1) begin tile++; ph = 2; end
                    else begin tile = 0; ph = 5; end
                end
            end else ph = 0;
        end
    end

    always @(negedge clk) begin
        chk("state", int'(state), ph);
        chk("busy", int'(busy), int'(ph != 0));
        chk("done", int'(done), int'(ph == 5));
        chk("ifm_read", int'(ifm_read), int'(ph == 1));
        chk("wr_buff_ifm", int'(wr_buff_ifm), int'(ph == 1 && valid_ifm));
        chk("wr_ifm_clr", int'(wr_ifm_clr), clr);
        chk("rd_ifm_clr", int'(rd_ifm_clr), int'(clr == 1 || (ph == 4 && beat == T - 1 && tile < NT - 1)));
        chk("wgt_read", int'(wgt_read), int'(ph == 2));
        chk("rd_buff_ifm", int'(rd_buff_ifm), int'(ph == 2 && wgt_valid));
        chk("set_reg", int'(set_reg), int'(ph == 2 && wgt_valid));
        chk("first_acc", int'(first_acc), int'(ph == 2 && words == 0));
        chk("set_output", int'(set_output), int'(ph == 3));
        chk("valid_data", int'(valid_data), int'(ph == 4));
        chk("sel_data", int'(sel_data), ph == 4 ? beat : 0);
        chk("counter_ifm", int'(counter_ifm), words);
        chk("counter_tiling", int'(counter_tiling), tile);
    end

    // Pulse counters: busy, valid_data, rd_ifm_clr, wr_buff, load, first_acc, done, set_output, compute
    int n[9], b[9];
    always @(negedge clk) if (rst_n) begin
        n[0] += int'(busy); n[1] += int'(valid_data); n[2] += int'(rd_ifm_clr);
        n[3] += int'(wr_buff_ifm); n[4] += int'(state == 3'd1); n[5] += int'(first_acc);
        n[6] += int'(done); n[7] += int'(set_output); n[8] += int'(state == 3'd2);
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic snap(); for (int i = 0; i < 9; i++) b[i] = n[i]; endtask
    task automatic run_layer(string tag);
        int k;
        start = 1; step(); start = 0;
        for (k = 0; k < 200 && !done; k++) step();
        chk({tag, "_done_seen"}, int'(done), 1);
        step();
    endtask

    initial begin
        valid_ifm = 1; wgt_valid = 1;
        repeat (3) step();
        chk("reset_state", int'(state), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1; step();

        snap(); run_layer("l1");
        chk("l1_busy_cycles", n[0] - b[0], 31);
        chk("l1_vd_beats", n[1] - b[1], 16);
        chk("l1_rd_clr", n[2] - b[2], 2);
        chk("l1_wr_buff", n[3] - b[3], 4);
        chk("l1_load_cycles", n[4] - b[4], 4);
        chk("l1_first_acc", n[5] - b[5], 2);
        chk("l1_done", n[6] - b[6], 1);
        chk("l1_set_output", n[7] - b[7], 2);
        chk("l1_compute_cycles", n[8] - b[8], 8);

        snap();
        start = 1; step(); start = 0;
        step(); step();
        valid_ifm = 0; step(); step(); valid_ifm = 1;
        for (int k = 0; k < 200 && !done; k++) step();
        chk("l2_done_seen", int'(done), 1);
        step();
        chk("l2_load_cycles", n[4] - b[4], 6);
        chk("l2_wr_buff", n[3] - b[3], 4);
        chk("l2_busy_cycles", n[0] - b[0], 33);

        snap();
        start = 1; step(); start = 0;
        for (int k = 0; k < 50 && !(state == 3'd2 && counter_ifm == 16'd2); k++) step();
        chk("l3_reach_cnt2", int'(counter_ifm), 2);
        wgt_valid = 0; step(); step();
        start = 1; step(); start = 0;
        chk("l3_hold_cnt", int'(counter_ifm), 2);
        chk("l3_hold_state", int'(state), 2);
        wgt_valid = 1;
        for (int k = 0; k < 200 && !done; k++) step();
        chk("l3_done_seen", int'(done), 1);
        step();
        chk("l3_compute_cycles", n[8] - b[8], 11);
        chk("l3_first_acc", n[5] - b[5], 2);
        chk("l3_busy_cycles", n[0] - b[0], 34);
        chk("l3_idle_after", int'(state), 0);

        start = 1; step(); start = 0;
        for (int k = 0; k < 100 && !(valid_data && sel_data == 3'd5); k++) step();
        chk("rst_reach_sel5", int'(sel_data), 5);
        #2 rst_n = 0;
        #1;
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_vd", int'(valid_data), 0);
        chk("rst_async_sel", int'(sel_data), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_tile", int'(counter_tiling), 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (5) step();
        chk("rst_stays_idle", int'(state), 0);

        snap(); run_layer("l4");
        chk("l4_vd_beats", n[1] - b[1], 16);
        chk("l4_busy_cycles", n[0] - b[0], 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
